// File: rtl/led_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// led_pattern_gen_if
// Purpose : groups the run-control inputs and the LED/strobe outputs of
//           led_pattern_gen into one bundle.
// Signals : en   - run enable, synchronous to clk
//           mode - pattern select (0 binary, 1 scan, 2 breathe, 3 off)
//           leds - registered LED drive, 1 = lit
//           tick - registered single-cycle step strobe
// Modports: master drives en/mode and observes leds/tick;
//           slave (the generator) receives en/mode and drives leds/tick.
// ---------------------------------------------------------------------------
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 8
);
    logic                en;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] leds;
    logic                tick;

    modport master (output en, output mode, input leds, input tick);
    modport slave  (input en, input mode, output leds, output tick);
endinterface

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Purpose : LED pattern generator. A prescaler divides clk by TICK_DIV to
//           produce pattern steps; the selected mode turns the step state
//           into a registered LED drive.
//             mode 0 binary  : NUM_LEDS-bit up counter
//             mode 1 scan    : one-hot bouncing dot, no repeated endpoint
//             mode 2 breathe : PWM duty ramps 0 -> max -> 0 per step
//             mode 3 off     : LEDs dark, prescaler and tick keep running
// Ports   : clk    - single clock, all state on its rising edge
//           resetn - asynchronous active-low reset
//           bus    - led_pattern_gen_if.slave (en, mode in; leds, tick out)
// ---------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int              NUM_LEDS = 8,
    parameter longint unsigned TICK_DIV = 64'd16777216,
    parameter int              PWM_BITS = 8
) (
    input  logic             clk,
    input  logic             resetn,
    led_pattern_gen_if.slave bus
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int POS_W = $clog2(NUM_LEDS);

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 64'd1);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]    POS_PEN  = POS_W'(NUM_LEDS - 2);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    logic [1:0]          mode_q,  mode_d;
    logic [PRE_W-1:0]    pre_q,   pre_d;
    logic [NUM_LEDS-1:0] cnt_q,   cnt_d;
    logic [POS_W-1:0]    pos_q,   pos_d;
    logic                dir_q,   dir_d;
    logic [PWM_BITS-1:0] duty_q,  duty_d;
    logic                bdir_q,  bdir_d;   // breathe ramp direction, 1 = falling
    logic [PWM_BITS-1:0] pwm_q,   pwm_d;
    logic [NUM_LEDS-1:0] leds_q,  leds_d;
    logic                tick_q,  tick_d;

    logic mode_chg;
    logic wrap;

    // A mode change outranks a coincident prescaler wrap: no step that cycle.
    assign mode_chg = (bus.mode != mode_q);
    assign wrap     = bus.en && !mode_chg && (pre_q == PRE_LAST);

    always_comb begin
        mode_d = mode_q;
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        duty_d = duty_q;
        bdir_d = bdir_q;
        pwm_d  = pwm_q;
        leds_d = leds_q;
        tick_d = 1'b0;

        if (mode_chg) begin
            // Restart the new pattern from step 0, independent of en.
            mode_d = bus.mode;
            pre_d  = '0;
            cnt_d  = '0;
            pos_d  = '0;
            dir_d  = 1'b0;
            duty_d = '0;
            bdir_d = 1'b0;
            pwm_d  = '0;
            leds_d = '0;
        end else if (bus.en) begin
            pre_d  = wrap ? '0 : pre_q + 1'b1;
            tick_d = wrap;
            pwm_d  = pwm_q + 1'b1;

            // LEDs follow the step state held before this edge, so they lag
            // a step by exactly one clock.
            case (mode_q)
                2'd0:    leds_d = cnt_q;
                2'd1:    leds_d = NUM_LEDS'(1) << pos_q;
                2'd2:    leds_d = {NUM_LEDS{pwm_q < duty_q}};
                default: leds_d = '0;
            endcase

            if (wrap) begin
                case (mode_q)
                    2'd0: cnt_d = cnt_q + 1'b1;
                    2'd1: begin
                        if (!dir_q) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = 1'b1;
                                pos_d = POS_PEN;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    2'd2: begin
                        if (!bdir_q) begin
                            if (duty_q == DUTY_MAX) begin
                                bdir_d = 1'b1;
                                duty_d = duty_q - 1'b1;
                            end else begin
                                duty_d = duty_q + 1'b1;
                            end
                        end else begin
                            if (duty_q == '0) begin
                                bdir_d = 1'b0;
                                duty_d = duty_q + 1'b1;
                            end else begin
                                duty_d = duty_q - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q <= '0;
            pre_q  <= '0;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            duty_q <= '0;
            bdir_q <= 1'b0;
            pwm_q  <= '0;
            leds_q <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            duty_q <= duty_d;
            bdir_q <= bdir_d;
            pwm_q  <= pwm_d;
            leds_q <= leds_d;
            tick_q <= tick_d;
        end
    end

    assign bus.leds = leds_q;
    assign bus.tick = tick_q;
endmodule
